// File: rtl/calc_core_seq_if.sv
// Operand/handshake/result-memory bundle shared by calc_core_seq and its host.
// The master side drives operands and commands; the slave side is the calculator core.
interface calc_core_seq_if #(
  parameter int WIDTH     = 8,
  parameter int MEM_DEPTH = 4,
  parameter int AW        = $clog2(MEM_DEPTH)
);
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [1:0]           op;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 overflow;
  logic                 div_by_zero;
  logic [1:0]           mem_cmd;
  logic [AW-1:0]        mem_addr;
  logic [2*WIDTH-1:0]   mem_rd_data;
  logic                 mem_rd_valid;
  logic [MEM_DEPTH-1:0] mem_slot_used;

  modport master (
    output a, b, op, start, mem_cmd, mem_addr,
    input  busy, done, result, overflow, div_by_zero,
    input  mem_rd_data, mem_rd_valid, mem_slot_used
  );

  modport slave (
    input  a, b, op, start, mem_cmd, mem_addr,
    output busy, done, result, overflow, div_by_zero,
    output mem_rd_data, mem_rd_valid, mem_slot_used
  );
endinterface

// File: rtl/calc_core_seq.sv
// Sequential 4-function calculator: single-cycle add/sub, iterative shift-add multiply
// and restoring divide, plus a small result memory with per-slot valid bits.
module calc_core_seq #(
  parameter int WIDTH     = 8,
  parameter int MEM_DEPTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  calc_core_seq_if.slave bus
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = 2 * WIDTH;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [1:0] CMD_STORE  = 2'b01;
  localparam logic [1:0] CMD_RECALL = 2'b10;
  localparam logic [1:0] CMD_CLEAR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10
  } state_t;

  state_t          r_state;
  logic            r_busy;
  logic            r_done;
  logic [1:0]      r_op;
  logic [WIDTH-1:0] r_b;
  logic [RW-1:0]   r_x;
  logic [RW-1:0]   r_y;
  logic [CW-1:0]   r_cnt;
  logic [RW-1:0]   r_result;
  logic            r_overflow;
  logic            r_dbz;
  logic [RW-1:0]   r_mem [MEM_DEPTH];
  logic [MEM_DEPTH-1:0] r_used;
  logic [RW-1:0]   r_rd_data;
  logic            r_rd_valid;

  logic [WIDTH:0]  w_sum;
  logic [WIDTH:0]  w_dif;
  logic [WIDTH:0]  w_shift;
  logic [WIDTH:0]  w_trial;
  logic [RW-1:0]   w_mul_acc;
  logic [RW-1:0]   w_div_x;
  logic [RW-1:0]   w_step;
  logic            w_last;

  // One iteration of either sequencer; divide keeps {remainder, quotient} in r_x.
  always_comb begin
    w_sum     = {1'b0, bus.a} + {1'b0, bus.b};
    w_dif     = {1'b0, bus.a} - {1'b0, bus.b};
    w_shift   = {r_x[RW-1:WIDTH], r_x[WIDTH-1]};
    w_trial   = w_shift - {1'b0, r_b};
    w_mul_acc = r_x + (r_b[0] ? r_y : {RW{1'b0}});
    if (w_trial[WIDTH] == 1'b0) begin
      w_div_x = {w_trial[WIDTH-1:0], r_x[WIDTH-2:0], 1'b1};
    end else begin
      w_div_x = {w_shift[WIDTH-1:0], r_x[WIDTH-2:0], 1'b0};
    end
    if (r_op == OP_MUL) begin
      w_step = w_mul_acc;
    end else begin
      w_step = w_div_x;
    end
    w_last = (r_cnt == CW'(WIDTH - 1));
  end

  // Operation FSM and result registers; inputs are latched at acceptance only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_op       <= OP_ADD;
      r_b        <= {WIDTH{1'b0}};
      r_x        <= {RW{1'b0}};
      r_y        <= {RW{1'b0}};
      r_cnt      <= {CW{1'b0}};
      r_result   <= {RW{1'b0}};
      r_overflow <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_op   <= bus.op;
            r_b    <= bus.b;
            r_cnt  <= {CW{1'b0}};
            r_busy <= 1'b1;
            case (bus.op)
              OP_ADD: begin
                r_result   <= {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
                r_overflow <= w_sum[WIDTH];
                r_dbz      <= 1'b0;
                r_done     <= 1'b1;
                r_state    <= S_FIN;
              end
              OP_SUB: begin
                r_result   <= {{WIDTH{1'b0}}, w_dif[WIDTH-1:0]};
                r_overflow <= w_dif[WIDTH];
                r_dbz      <= 1'b0;
                r_done     <= 1'b1;
                r_state    <= S_FIN;
              end
              OP_MUL: begin
                r_x     <= {RW{1'b0}};
                r_y     <= {{WIDTH{1'b0}}, bus.a};
                r_state <= S_RUN;
              end
              OP_DIV: begin
                if (bus.b == {WIDTH{1'b0}}) begin
                  r_result   <= {bus.a, {WIDTH{1'b1}}};
                  r_overflow <= 1'b1;
                  r_dbz      <= 1'b1;
                  r_done     <= 1'b1;
                  r_state    <= S_FIN;
                end else begin
                  r_x     <= {{WIDTH{1'b0}}, bus.a};
                  r_state <= S_RUN;
                end
              end
              default: r_state <= S_IDLE;
            endcase
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_RUN: begin
          r_x   <= w_step;
          r_cnt <= r_cnt + CW'(1);
          if (r_op == OP_MUL) begin
            r_y <= r_y << 1;
            r_b <= r_b >> 1;
          end
          if (w_last) begin
            r_result   <= w_step;
            r_overflow <= 1'b0;
            r_dbz      <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_FIN;
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Result memory: store captures the pre-edge result, so a FIN-cycle store sees the new value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= {RW{1'b0}};
      r_used     <= {MEM_DEPTH{1'b0}};
      r_rd_data  <= {RW{1'b0}};
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      case (bus.mem_cmd)
        CMD_STORE: begin
          r_mem[bus.mem_addr]  <= r_result;
          r_used[bus.mem_addr] <= 1'b1;
        end
        CMD_RECALL: begin
          r_rd_data  <= r_mem[bus.mem_addr];
          r_rd_valid <= 1'b1;
        end
        CMD_CLEAR: begin
          for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= {RW{1'b0}};
          r_used <= {MEM_DEPTH{1'b0}};
        end
        default: r_rd_valid <= 1'b0;
      endcase
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.result        = r_result;
  assign bus.overflow      = r_overflow;
  assign bus.div_by_zero   = r_dbz;
  assign bus.mem_rd_data   = r_rd_data;
  assign bus.mem_rd_valid  = r_rd_valid;
  assign bus.mem_slot_used = r_used;

endmodule

// File: tb/tb_calc_core_seq.sv
// Directed bench for calc_core_seq (WIDTH=8, MEM_DEPTH=4): an arithmetic/latency model
// is compared every cycle, and literal expectations pin the model on the documented cases.
module tb_calc_core_seq;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  bit   cmp_en;

  calc_core_seq_if #(.WIDTH(8), .MEM_DEPTH(4)) bus ();

  calc_core_seq #(.WIDTH(8), .MEM_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {div_by_zero, overflow, result} from plain arithmetic.
  function automatic logic [17:0] exp_calc(input logic [7:0] x, input logic [7:0] y,
                                           input logic [1:0] o);
    int xi, yi, s;
    logic [15:0] r;
    logic ov, dz;
    xi = int'(x);
    yi = int'(y);
    ov = 1'b0;
    dz = 1'b0;
    case (o)
      2'd0: begin s = xi + yi; r = 16'(s % 256); ov = (s > 255); end
      2'd1: begin s = (xi - yi + 256) % 256; r = 16'(s); ov = (xi < yi); end
      2'd2: r = 16'(xi * yi);
      default: begin
        if (yi == 0) begin r = {x, 8'hFF}; ov = 1'b1; dz = 1'b1; end
        else r = 16'((xi % yi) * 256 + xi / yi);
      end
    endcase
    return {dz, ov, r};
  endfunction

  function automatic int exp_lat(input logic [7:0] y, input logic [1:0] o);
    if (o == 2'd0 || o == 2'd1 || (o == 2'd3 && y == 8'd0)) return 1;
    return 9;
  endfunction

  // Model: m_left counts busy cycles still to come; the last one is the done cycle.
  int          m_left;
  logic [17:0] m_pend;
  logic [15:0] m_result;
  logic        m_ovf, m_dbz;
  logic [15:0] m_mem [4];
  logic [3:0]  m_used;
  logic [15:0] m_rd_data;
  logic        m_rd_valid;
  logic [17:0] m_now;
  int          m_lat_now;

  assign m_now     = exp_calc(bus.a, bus.b, bus.op);
  assign m_lat_now = exp_lat(bus.b, bus.op);

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left <= 0; m_pend <= 18'd0; m_result <= 16'd0; m_ovf <= 1'b0; m_dbz <= 1'b0;
      for (int i = 0; i < 4; i++) m_mem[i] <= 16'd0;
      m_used <= 4'd0; m_rd_data <= 16'd0; m_rd_valid <= 1'b0;
    end else begin
      m_rd_valid <= (bus.mem_cmd == 2'b10);
      if (bus.mem_cmd == 2'b01) begin
        m_mem[bus.mem_addr] <= m_result;
        m_used[bus.mem_addr] <= 1'b1;
      end else if (bus.mem_cmd == 2'b10) begin
        m_rd_data <= m_mem[bus.mem_addr];
      end else if (bus.mem_cmd == 2'b11) begin
        for (int i = 0; i < 4; i++) m_mem[i] <= 16'd0;
        m_used <= 4'd0;
      end
      if (m_left == 0) begin
        if (bus.start) begin
          m_left <= m_lat_now;
          m_pend <= m_now;
          if (m_lat_now == 1) begin
            m_result <= m_now[15:0]; m_ovf <= m_now[16]; m_dbz <= m_now[17];
          end
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 2) begin
          m_result <= m_pend[15:0]; m_ovf <= m_pend[16]; m_dbz <= m_pend[17];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy",         32'(bus.busy),          32'(m_left != 0));
      check("done",         32'(bus.done),          32'(m_left == 1));
      check("result",       32'(bus.result),        32'(m_result));
      check("overflow",     32'(bus.overflow),      32'(m_ovf));
      check("div_by_zero",  32'(bus.div_by_zero),   32'(m_dbz));
      check("slot_used",    32'(bus.mem_slot_used), 32'(m_used));
      check("rd_valid",     32'(bus.mem_rd_valid),  32'(m_rd_valid));
      check("rd_data",      32'(bus.mem_rd_data),   32'(m_rd_data));
    end
  end

  // Issue one op; scrambles the operands after acceptance and optionally pokes start at cycle 'poke'.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] top,
                        input int poke, output int cyc);
    @(posedge clk); #2;
    bus.a = ta; bus.b = tb; bus.op = top; bus.start = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #2;
      if (c == 1) begin bus.a = 8'h55; bus.b = 8'h00; bus.op = 2'b11; end
      bus.start = (c == poke) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (bus.done) begin cyc = c; break; end
    end
    bus.start = 1'b0;
  endtask

  task automatic mem_op(input logic [1:0] cmd, input logic [1:0] addr);
    @(posedge clk); #2;
    bus.mem_cmd = cmd; bus.mem_addr = addr;
    @(posedge clk); #2;
    bus.mem_cmd = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    n_cmp = 0; n_err = 0; cmp_en = 1'b0;
    rst_n = 1'b0;
    bus.a = 8'd0; bus.b = 8'd0; bus.op = 2'b00; bus.start = 1'b0;
    bus.mem_cmd = 2'b00; bus.mem_addr = 2'd0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1; cmp_en = 1'b1;
    @(negedge clk);
    check("reset_result", 32'(bus.result), 32'h0);
    check("reset_busy",   32'(bus.busy),   32'h0);

    run_op(8'd200, 8'd100, 2'b00, 0, cyc);
    check("add_lat", 32'(cyc), 32'd1);
    check("add_res", 32'(bus.result), 32'h002C);
    check("add_ovf", 32'(bus.overflow), 32'h1);
    run_op(8'd5, 8'd9, 2'b01, 0, cyc);
    check("sub_res", 32'(bus.result), 32'h00FC);
    check("sub_ovf", 32'(bus.overflow), 32'h1);

    run_op(8'd255, 8'd255, 2'b10, 4, cyc);
    check("mul_lat", 32'(cyc), 32'd9);
    check("mul_res", 32'(bus.result), 32'hFE01);
    check("mul_ovf", 32'(bus.overflow), 32'h0);

    mem_op(2'b01, 2'd2);
    check("store_used", 32'(bus.mem_slot_used), 32'h4);
    mem_op(2'b10, 2'd2);
    check("recall2_data",  32'(bus.mem_rd_data),  32'hFE01);
    check("recall2_valid", 32'(bus.mem_rd_valid), 32'h1);
    @(negedge clk);
    check("recall2_pulse", 32'(bus.mem_rd_valid), 32'h0);
    mem_op(2'b10, 2'd1);
    check("recall1_data", 32'(bus.mem_rd_data), 32'h0000);

    run_op(8'd200, 8'd7, 2'b11, 0, cyc);
    check("div_lat", 32'(cyc), 32'd9);
    check("div_res", 32'(bus.result), 32'h041C);
    run_op(8'd13, 8'd0, 2'b11, 0, cyc);
    check("div0_lat", 32'(cyc), 32'd1);
    check("div0_res", 32'(bus.result), 32'h0DFF);
    check("div0_ovf", 32'(bus.overflow), 32'h1);
    check("div0_dbz", 32'(bus.div_by_zero), 32'h1);

    mem_op(2'b11, 2'd0);
    check("clear_used", 32'(bus.mem_slot_used), 32'h0);

    // Store in the FIN cycle of add 3+4.
    @(posedge clk); #2;
    bus.a = 8'd3; bus.b = 8'd4; bus.op = 2'b00; bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0; bus.mem_cmd = 2'b01; bus.mem_addr = 2'd0;
    @(posedge clk); #2;
    bus.mem_cmd = 2'b00;
    mem_op(2'b10, 2'd0);
    check("fin_store", 32'(bus.mem_rd_data), 32'h0007);

    // Reset in cycle 5 of a multiply.
    @(posedge clk); #2;
    bus.a = 8'd3; bus.b = 8'd3; bus.op = 2'b10; bus.start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #2;
      bus.start = 1'b0;
      if (c == 5) rst_n = 1'b0;
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy",   32'(bus.busy),   32'h0);
    check("rst_done",   32'(bus.done),   32'h0);
    check("rst_result", 32'(bus.result), 32'h0);
    run_op(8'd1, 8'd1, 2'b00, 0, cyc);
    check("post_rst_lat", 32'(cyc), 32'd1);
    check("post_rst_res", 32'(bus.result), 32'h0002);

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1);
  end
endmodule

// File: doc/calc_core_seq.md
# calc_core_seq

Parametrised, clocked successor to the 4-function calculator datapath. It performs add, subtract, multiply and divide on WIDTH-bit unsigned operands. Multiply and divide use iterative shift-add and restoring-division sequencers behind a start/busy/done handshake. Results go into a multi-slot result memory with per-slot valid bits. The block sits between the switch/key input conditioning and the BCD/seven-segment display path, which consumes `result` and `mem_rd_data`.

## Interface

Parameters:
- WIDTH, 8: operand width in bits (≥2).
- MEM_DEPTH, 4: number of memory slots (power of 2, ≥2). AW = log2(MEM_DEPTH).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand.
- op  in  2  operation: 00 add, 01 sub, 10 mul, 11 div.
- start  in  1  request; sampled only in IDLE.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- result  out  2*WIDTH  last completed result; held between operations.
- overflow  out  1  overflow/borrow/div-zero flag for `result`.
- div_by_zero  out  1  last operation was a divide with b=0.
- mem_cmd  in  2  memory command: 00 none, 01 store, 10 recall, 11 clear-all.
- mem_addr  in  AW  slot for store and recall.
- mem_rd_data  out  2*WIDTH  recalled value.
- mem_rd_valid  out  1  one-cycle pulse qualifying `mem_rd_data`.
- mem_slot_used  out  MEM_DEPTH  per-slot valid bits.

## Operation

- FSM states: IDLE, RUN, FIN. `busy` = (state != IDLE). `done` = (state == FIN).
- IDLE with start=1: latch a, b and op.
  - add, sub, or div with b=0 → FIN.
  - mul, or div with b≠0 → RUN with iteration counter = 0.
- RUN:
  - Performs one shift-add (mul) or one restore step (div) per cycle for WIDTH cycles.
  - When the counter reaches WIDTH-1 → FIN.
- FIN always returns to IDLE after one cycle.
- `result`, `overflow` and `div_by_zero` load on the edge entering FIN and hold until the next FIN or reset.
- Arithmetic:
  - add: result = zero-extended (a+b) mod 2^WIDTH; overflow = carry-out.
  - sub: result = zero-extended (a−b) mod 2^WIDTH; overflow = borrow (a<b).
  - mul: result = full 2*WIDTH product; overflow = 0.
  - div, b≠0: result = {remainder, quotient}, each WIDTH bits; overflow = 0.
  - div, b=0: quotient = all ones, remainder = a; overflow = 1; div_by_zero = 1.
  - div_by_zero = 0 for every other operation.
- `start` while busy (including the FIN cycle) is ignored. It is neither queued nor an error.
- Changes to a, b or op after acceptance have no effect on the running operation.
- Memory commands are processed every cycle, independent of FSM state:
  - store: slot[mem_addr] ← current `result` output value; mem_slot_used[mem_addr] ← 1.
  - recall: mem_rd_data ← slot[mem_addr] on the next edge; mem_rd_valid = 1 for that one cycle. An unused slot reads 0.
  - clear-all: every slot ← 0; mem_slot_used ← 0. mem_rd_data keeps its value.
- Store in a FIN cycle writes the new result, because `result` is already updated in that cycle.

## Timing

- Start accepted in cycle 0. busy=1 in cycles 1..N. done=1 in cycle N only. N is:
  - 1 for add, sub, and div with b=0.
  - WIDTH+1 for mul and div with b≠0.
- The next start can be accepted from cycle N+1 onward.
- Recall latency is 1 cycle. Back-to-back recalls give one valid pulse per command.
- Reset (rst_n=0 at an edge), including mid-RUN: state → IDLE, and the following all go to 0:
  - busy, done, result, overflow, div_by_zero
  - mem_rd_data, mem_rd_valid
  - all slots and mem_slot_used
- An operation in flight at reset is discarded, with no done pulse.
- Simultaneous start and mem_cmd are both serviced. Store samples the pre-edge `result`.

## Test plan

All scenarios use WIDTH=8, MEM_DEPTH=4.
- add 200+100 → done in cycle 1; result=0x002C, overflow=1. Then sub 5−9 → result=0x00FC, overflow=1.
- mul 255×255 → busy cycles 1–9, done only in cycle 9; result=0xFE01, overflow=0. A start pulse in cycle 4 is ignored.
- div 200/7 → done in cycle 9; result=0x041C (r=4, q=28). Then div 13/0 → done in cycle 1; result=0x0DFF, overflow=1, div_by_zero=1.
- After the mul, store to slot 2 → mem_slot_used=0b0100. Recall 2 → next cycle mem_rd_data=0xFE01 with a single-cycle mem_rd_valid. Recall 1 → 0x0000. Clear-all → mem_slot_used=0.
- Store issued in the FIN cycle of add 3+4 → the slot holds 0x0007, not the previous result.
- rst_n low in cycle 5 of a mul → next cycle busy=0 and result=0, with no done pulse. A new add 1+1 then completes normally with 0x0002.
